// File: rtl/sect163k1_pt_chk.sv
// Sequential sect163k1 point validator: checks y^2 + xy == x^3 + x^2 + 1 with one bit-serial GF(2^163) multiplier.
// Optional macro SECT163K1_PT_CHK_INF_EN: treats start with x == 0, y == 0 as the point at infinity (valid in one step).
module sect163k1_pt_chk (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         start,
    input  logic [162:0] x,
    input  logic [162:0] y,
    output logic         busy,
    output logic         done,
    output logic         valid
);

    typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, CMP} state_t;

    // Low terms of f(z): z^7 + z^6 + z^3 + 1
    localparam logic [162:0] RED_POLY = 163'h0C9;
    localparam logic [7:0]   CNT_TOP  = 8'd162;

    state_t       state_q, state_d;
    logic [162:0] xr_q, yr_q, acc_q, s_q, t_q;
    logic [7:0]   cnt_q;
    logic         done_q, valid_q;

    logic [162:0] opA, opB, accShift, accStep;
    logic         lastStep, zeroIn, zeroPt, onCurve;

`ifdef SECT163K1_PT_CHK_INF_EN
    assign zeroIn = (x == '0) && (y == '0);
    assign zeroPt = (xr_q == '0) && (yr_q == '0);
`else
    assign zeroIn = 1'b0;
    assign zeroPt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = zeroIn ? CMP : MUL1;
                MUL1:    if (lastStep) state_d = MUL2;
                MUL2:    if (lastStep) state_d = MUL3;
                MUL3:    if (lastStep) state_d = CMP;
                CMP:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Operand routing for the shared multiplier plus one MSB-first step
    always_comb begin
        busy = (state_q != IDLE);
        opA  = '0;
        opB  = '0;
        case (state_q)
            MUL1: begin
                opA = xr_q;
                opB = xr_q;
            end
            MUL2: begin
                opA = yr_q;
                opB = yr_q ^ xr_q;
            end
            MUL3: begin
                opA = s_q;
                opB = xr_q ^ 163'd1;
            end
            default: begin
                opA = '0;
                opB = '0;
            end
        endcase
        accShift = {acc_q[161:0], 1'b0} ^ (acc_q[162] ? RED_POLY : '0);
        accStep  = accShift ^ (opB[cnt_q] ? opA : '0);
        lastStep = (cnt_q == 8'd0);
        onCurve  = zeroPt || (t_q == (acc_q ^ 163'd1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr_q    <= '0;
            yr_q    <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            t_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (clr) begin
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        xr_q  <= x;
                        yr_q  <= y;
                        acc_q <= '0;
                        cnt_q <= CNT_TOP;
                    end
                end
                MUL1: begin
                    if (lastStep) begin
                        s_q   <= accStep;
                        acc_q <= '0;
                        cnt_q <= CNT_TOP;
                    end else begin
                        acc_q <= accStep;
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                MUL2: begin
                    if (lastStep) begin
                        t_q   <= accStep;
                        acc_q <= '0;
                        cnt_q <= CNT_TOP;
                    end else begin
                        acc_q <= accStep;
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                // u = x^3 + x^2 stays in acc for the compare
                MUL3: begin
                    acc_q <= accStep;
                    if (!lastStep) cnt_q <= cnt_q - 8'd1;
                end
                CMP: begin
                    valid_q <= onCurve;
                    done_q  <= 1'b1;
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign done  = done_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_sect163k1_pt_chk.sv
// Self-checking bench for sect163k1_pt_chk: directed curve points, handshake corner cases and random operands
// checked against an LSB-first polynomial-arithmetic reference of the curve equation.
module tb_sect163k1_pt_chk;

    localparam logic [162:0] GX  = 163'h2FE13C0537BBC11ACAA07D793DE4E6D5E5C94EEE8;
    localparam logic [162:0] GY  = 163'h289070FB05D38FF58321F2E800536D538CCDAA3D9;
    localparam logic [162:0] GYB = 163'h289070FB05D38FF58321F2E800536D538CCDAA3D8;
    localparam int FULL_LAT = 490;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         start = 1'b0;
    logic [162:0] x = '0;
    logic [162:0] y = '0;
    logic         busy, done, valid;

    int checks = 0;
    int errors = 0;

    sect163k1_pt_chk dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .valid (valid)
    );

    always #5 clk = ~clk;

    // Reference field product: plain polynomial multiply, LSB-first, reduced by f(z)
    function automatic logic [162:0] gfMul(input logic [162:0] a, input logic [162:0] b);
        logic [162:0] r;
        logic [162:0] aa;
        logic         carry;
        r  = '0;
        aa = a;
        for (int i = 0; i < 163; i++) begin
            if (b[i]) r = r ^ aa;
            carry = aa[162];
            aa = aa << 1;
            if (carry) aa = aa ^ 163'h0C9;
        end
        return r;
    endfunction

    function automatic logic refValid(input logic [162:0] px, input logic [162:0] py);
        logic [162:0] lhs, rhs, x2;
`ifdef SECT163K1_PT_CHK_INF_EN
        if (px == '0 && py == '0) return 1'b1;
`endif
        x2  = gfMul(px, px);
        lhs = gfMul(py, py) ^ gfMul(px, py);
        rhs = gfMul(x2, px) ^ x2 ^ 163'd1;
        return (lhs == rhs);
    endfunction

    function automatic int refLat(input logic [162:0] px, input logic [162:0] py);
`ifdef SECT163K1_PT_CHK_INF_EN
        if (px == '0 && py == '0) return 1;
`endif
        return FULL_LAT;
    endfunction

    function automatic logic [162:0] randElem();
        logic [162:0] v;
        v = '0;
        for (int k = 0; k < 6; k++) v = (v << 32) | 163'($urandom());
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Pulses start for one edge; returns just after that accepting edge
    task automatic applyStimulus(input logic [162:0] ax, input logic [162:0] ay);
        @(negedge clk);
        x     = ax;
        y     = ay;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done; optionally drives an extra start at cycle injectAt that must be ignored
    task automatic waitDone(input int injectAt, input logic [162:0] ix, input logic [162:0] iy,
                            output int lat, output bit busyOk, output bit validHeld);
        logic v0;
        lat       = 0;
        busyOk    = busy;
        v0        = valid;
        validHeld = 1'b1;
        while (lat < 600) begin
            if (lat == injectAt) begin
                x     = ix;
                y     = iy;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
            if (!busy) busyOk = 1'b0;
            if (valid !== v0) validHeld = 1'b0;
        end
        start = 1'b0;
        if (busy) busyOk = 1'b0;
    endtask

    task automatic runPoint(input string tag, input logic [162:0] px, input logic [162:0] py);
        int lat;
        bit bOk, vHeld;
        applyStimulus(px, py);
        waitDone(-1, '0, '0, lat, bOk, vHeld);
        checkOutput({tag, "_lat"}, 64'(lat), 64'(refLat(px, py)));
        checkOutput({tag, "_valid"}, 64'(valid), 64'(refValid(px, py)));
        checkOutput({tag, "_busy"}, 64'(bOk), 64'd1);
    endtask

    initial begin
        int  lat;
        bit  bOk, vHeld;
        int  doneSeen;
        logic [162:0] rx, ry;

        #12;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_valid", 64'(valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runPoint("gen", GX, GY);
        checkOutput("gen_const", 64'(valid), 64'd1);
        runPoint("gen_flip", GX, GYB);
        checkOutput("gen_flip_const", 64'(valid), 64'd0);
        runPoint("order2", 163'd0, 163'd1);
        checkOutput("order2_const", 64'(valid), 64'd1);
        runPoint("zero", 163'd0, 163'd0);

        for (int i = 0; i < 3; i++) begin
            rx = randElem();
            ry = randElem();
            runPoint($sformatf("rand%0d", i), rx, ry);
        end

        // Start during busy is ignored; back-to-back start on the done cycle holds valid until its own done
        runPoint("pre_b2b", GX, GYB);
        applyStimulus(GX, GY);
        waitDone(99, GX, GYB, lat, bOk, vHeld);
        checkOutput("ignore_lat", 64'(lat), 64'(FULL_LAT));
        checkOutput("ignore_valid", 64'(valid), 64'd1);
        x     = GX;
        y     = GYB;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_busy", 64'(busy), 64'd1);
        checkOutput("b2b_valid_kept", 64'(valid), 64'd1);
        waitDone(-1, '0, '0, lat, bOk, vHeld);
        checkOutput("b2b_lat", 64'(lat), 64'(FULL_LAT));
        checkOutput("b2b_held", 64'(vHeld), 64'd1);
        checkOutput("b2b_valid", 64'(valid), 64'd0);

        // Synchronous clear mid-operation
        runPoint("pre_clr", GX, GY);
        applyStimulus(GX, GY);
        repeat (199) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("clr_busy", 64'(busy), 64'd0);
        checkOutput("clr_valid", 64'(valid), 64'd0);
        doneSeen = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) doneSeen++;
        end
        checkOutput("clr_no_done", 64'(doneSeen), 64'd0);
        runPoint("post_clr", GX, GY);

        // Asynchronous reset mid-operation, mid-cycle
        applyStimulus(GX, GY);
        repeat (299) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_done", 64'(done), 64'd0);
        checkOutput("arst_valid", 64'(valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runPoint("post_rst", GX, GYB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sect163k1_pt_chk.md
Name: sect163k1_pt_chk

Overview:
Sequential point validator for sect163k1 over GF(2^163), with reduction polynomial f(z) = z^163 + z^7 + z^6 + z^3 + 1.
- Consumes an affine (x, y) pair, e.g. the result of sect163k1_pt_mul or an externally supplied public key.
- Reports whether the pair satisfies y^2 + xy = x^3 + x^2 + 1.
- Sits on the read side of the point-multiplier interface and uses the same start/done/clr handshake.
- Implemented with one shared bit-serial (MSB-first) GF(2^163) multiplier.

Parameters:
None. Field, reduction polynomial and curve constants (a = 1, b = 1) are fixed.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear; aborts any operation
- start  input  1  one-cycle request; x, y sampled on the same edge
- x  input  163  affine x coordinate
- y  input  163  affine y coordinate
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when the result is available
- valid  output  1  1 = point on curve; held until next accepted start or clr

Behaviour:
- Reset (rst_n=0, async): FSM to IDLE; busy=0, done=0, valid=0; all datapath registers 0.
- clr=1 (sync, priority over start): FSM to IDLE; busy=0, done=0, valid=0; an in-flight operation is discarded with no done pulse.
- Acceptance: start=1 in IDLE latches x, y into xr, yr. start while busy=1 is ignored, and the latched operands do not change.
- States: IDLE -> MUL1 (163 cyc) -> MUL2 (163 cyc) -> MUL3 (163 cyc) -> CMP (1 cyc) -> IDLE.
- Operations per state:
  - MUL1: s = xr*xr mod f
  - MUL2: t = yr*(yr ^ xr) mod f, i.e. y^2 + xy
  - MUL3: u = s*(xr ^ 1) mod f, i.e. x^3 + x^2
  - CMP: valid <= (t == (u ^ 1)); done <= 1 for exactly one cycle; busy <= 0.
- Multiplier: MSB-first shift-and-add.
  - Step: acc <= (acc<<1 reduced by f) ^ (b[i] ? a : 0), for i = 162 down to 0.
  - Reduction: fold bit 163 into bits 7, 6, 3 and 0.
  - An 8-bit counter runs 162..0; the last step moves the FSM to the next state.
  - acc is cleared on entry to each MUL state.
- Latency: start sampled on edge E0; done=1 and valid updated after edge E0+490 (3*163 + 1).
- busy=1 from E0 through E0+489.
- Back-to-back: start on the cycle done=1 is accepted (FSM already IDLE). valid stays at the old value until that new operation's CMP; it is not cleared on acceptance.
- All 163-bit inputs are legal field elements; no input range check.
- (0,0) is treated as an ordinary input; it fails the equation, so valid=0.

Optional Feature:
- Macro: SECT163K1_PT_CHK_INF_EN.
- Defined: start with x == 0 and y == 0 is treated as the point at infinity.
  - FSM goes IDLE -> CMP directly, skipping all multiplies.
  - done pulses after edge E0+1 with valid=1.
  - busy is high for one cycle.
- Undefined: no zero detect and no shortcut. (0,0) takes the full 490 cycles and returns valid=0.

Test Plan:
1. Generator: x=2FE13C0537BBC11ACAA07D793DE4E6D5E5C94EEE8, y=289070FB05D38FF58321F2E800536D538CCDAA3D9 -> done after 490 cycles, valid=1.
2. Same generator with y LSB flipped (…3D8) -> done after 490 cycles, valid=0. Order-2 point x=0, y=1 -> valid=1.
3. x=0, y=0:
   - macro undefined -> valid=0 at 490 cycles.
   - macro defined -> valid=1, done one cycle after start.
4. Start case 1, assert start with case 2 operands at cycle 100 -> ignored; result valid=1 at cycle 490. Then start case 2 on the done cycle -> valid stays 1 until the new done 490 cycles later, then becomes 0.
5. Start case 1, pulse clr at cycle 200 -> busy=0 next cycle, no done pulse, valid=0. A new start of case 1 then completes normally with valid=1.
6. Start case 1, drop rst_n at cycle 300 (async, mid-cycle) -> busy/done/valid=0 immediately. After release, case 2 runs to valid=0 at 490 cycles.
